spi_host: RTL
=============

// Module: spi_host
// PURPOSE
//  Parametrised SPI master on the Z80 I/O bus, successor to the fixed single-slave mode-0 SPI path in the top level.
//  Adds N chip selects, CPOL/CPHA modes, MSB/LSB order, a programmable SCK divider, full-duplex capture and a sticky guard fault.
//  Sits between the stabilized bus strobes (io_read/io_write, phi_edge) and the SPI pins. The top level drives the tristates.
// PARAMETERS
//  BASE_ADDR   16'h0100  I/O base; CTRL=BASE+0, DIV=BASE+1, DATA=BASE+4 (A[15:0] full decode)
//  NUM_CS      2         chip-select lines, 1..8
//  DIV_WIDTH   8         width of the divider register
//  DIV_RESET   0         divider reset value; SCK half-period = (DIV+1) CLK1 cycles
//  WAIT_TAIL   3         on a DATA read, wait is held while bits remaining > WAIT_TAIL
// PORTS
//  CLK1       in   1         system clock
//  RESET      in   1         asynchronous, active-high reset
//  phi_edge   in   1         one-CLK1 pulse per stabilized PHI rising edge
//  io_read    in   1         stabilized !IORQ & !RD
//  io_write   in   1         stabilized !IORQ & !WR
//  addr       in   16        A[15:0]
//  din        in   8         D bus input
//  dout       out  8         read data
//  dout_en    out  1         drive D with dout
//  wait_en    out  1         pull /WAIT low
//  SPI_SCK    out  1         serial clock
//  SPI_SDO    out  1         serial data out
//  SPI_SDI    in   1         serial data in
//  SPI_SS     out  NUM_CS    active-low selects
// BEHAVIOUR
//  Reset: state IDLE; CTRL=0; DIV=DIV_RESET; rx=8'hFF; fault=0; dout=0; dout_en=0; wait_en=0; SPI_SS all 1; SPI_SCK=0; SPI_SDO=1.
//  CTRL read/write layout:
//    [2:0] cs_sel   [3] cs_en   [4] cpol   [5] cpha   [6] lsb_first   [7] fault (RO, sticky).
//    Writing CTRL with bit7=1 clears fault.
//  Chip selects: SPI_SS[cs_sel] = ~cs_en, all other lines 1. A cs_sel value >= NUM_CS selects no line.
//  Guard: cs_en 0->1 arms "first byte". If the first DATA write is 3B/6B/EB/BB/77/32/92/94:
//    cs_en<=0, fault<=1, and no transfer runs.
//  Register read: dout_en<=1 the CLK1 cycle after io_read with a decoded addr; it deasserts the cycle after io_read drops.
//  FSM IDLE:
//    CTRL/DIV access -> COMPLETE.
//    DATA write -> XFER with tx=din.
//    DATA read -> XFER with tx=8'hFF.
//    Undecoded address: stay IDLE.
//  FSM XFER:
//    16 SCK half-periods of (DIV+1) CLK1 cycles each.
//    SCK idles at cpol and toggles at the end of each half-period.
//    cpha=0: the first bit is on SDO at XFER entry; sample on the leading edge, shift on the trailing edge.
//    cpha=1: shift on the leading edge, sample on the trailing edge.
//    Bit order: lsb_first picks tx[0]/rx-into-MSB; otherwise tx[7]/rx-into-LSB.
//    After the last edge: rx<=shift register, dout<=rx. Then COMPLETE if io_read|io_write is still high, else IDLE.
//    SDO=1 outside XFER.
//  FSM COMPLETE: -> IDLE when io_read=0 and io_write=0.
//  Wait: wait_en changes only on phi_edge cycles while in XFER.
//    Set to 1 on a DATA read while bits remaining > WAIT_TAIL, else 0.
//    Forced to 0 in every other state.
//  Simultaneous io_read & io_write: read wins.
//  CTRL/DIV writes during XFER are ignored; the bus stalls via the COMPLETE handshake only.
//  RESET mid-transfer: all outputs return to reset values asynchronously, SS deasserts, wait_en drops.
//  Divider counter wraps to 0 at DIV; DIV=0 gives SCK = CLK1/2.
// STRUCTURE
//  Shared include fpga20_defs.vh holds:
//    state encodings IDLE/XFER/COMPLETE, register offsets, CTRL bit indices, and the guard opcode list.
//  One natural sub-module: spi_shifter (divider + 8-bit shift/sample + edge generation).
//  The parent keeps bus decode, CTRL/DIV registers, the guard, wait and the FSM.
// TESTING
//  1. Reset, then read CTRL -> dout=8'h00, SPI_SS=2'b11, SCK=0, SDO=1, wait_en=0.
//  2. CTRL<=8'h08, DIV<=1, write DATA 8'hA5 (mode 0):
//     SS[0]=0, SDO=1,0,1,0,0,1,0,1 on rising edges, SCK period 4 CLK1, and the transfer takes 32 CLK1.
//  3. CTRL<=8'h39 (cs1, mode 3), SDI=8'h3C, read DATA:
//     wait_en=1 at the first phi_edge, 0 once bits remaining<=3, dout=8'h3C, SDO held 1.
//  4. CTRL<=8'h08 then write DATA 8'hEB:
//     no SCK edges, SS[0]->1, CTRL reads 8'h80.
//     Writing CTRL 8'h80 clears it to 8'h00.
//  5. CTRL<=8'h48 (lsb_first), write 8'h01: SDO=1 on the first bit then 0. A second write of 8'hEB transfers (guard only on the first byte).
//  6. Assert RESET at half-period 7 of a transfer:
//     SS=all 1, wait_en=0, SCK=0 immediately. The next DATA write runs a normal transfer.

Source files
------------

// File: rtl/spi_host_pkg.sv
// spi_host_pkg: shared FSM encoding, register map, CTRL bit positions and guard opcodes
package spi_host_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_COMPLETE} state_e;
    localparam logic [15:0] OFF_CTRL = 16'd0;
    localparam logic [15:0] OFF_DIV  = 16'd1;
    localparam logic [15:0] OFF_DATA = 16'd4;
    localparam int CS_EN = 3;
    localparam int CPOL  = 4;
    localparam int CPHA  = 5;
    localparam int LSB   = 6;
    function automatic logic is_guard(input logic [7:0] b);
        return b inside {8'h3B, 8'h6B, 8'hEB, 8'hBB, 8'h77, 8'h32, 8'h92, 8'h94};
    endfunction
endpackage

// File: rtl/spi_host_shifter.sv
// spi_host_shifter: SCK divider, edge generation and full-duplex 8-bit shift/sample
module spi_host_shifter #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [7:0]           tx_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic                 lsb_i,
    input  logic                 sdi_i,
    output logic                 sck_o,
    output logic                 sdo_o,
    output logic                 busy_o,
    output logic [7:0]           rx_o,
    output logic [3:0]           half_o
);
    logic                 busy_q, sck_q, samp_q, sdo_q;
    logic [7:0]           sh_q, sh_d;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [3:0]           half_q;
    logic                 edge_hit, lead, in_bit, out_bit;

    assign edge_hit = busy_q && cnt_q == div_i;
    assign lead     = ~half_q[0];
    assign in_bit   = cpha_i ? sdi_i : samp_q;
    assign out_bit  = lsb_i ? sh_q[0] : sh_q[7];
    assign sh_d     = lsb_i ? {in_bit, sh_q[7:1]} : {sh_q[6:0], in_bit};
    assign sck_o    = busy_q ? sck_q : cpol_i;
    assign sdo_o    = busy_q ? (cpha_i ? sdo_q : out_bit) : 1'b1;
    assign busy_o   = busy_q;
    assign rx_o     = sh_q;
    assign half_o   = half_q;

    // leading edges capture SDI (cpha=0) or launch the next bit (cpha=1); trailing edges shift
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            samp_q <= 1'b0;
            sdo_q  <= 1'b1;
            sh_q   <= 8'hFF;
            cnt_q  <= '0;
            half_q <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            sck_q  <= cpol_i;
            cnt_q  <= '0;
            half_q <= '0;
            sh_q   <= tx_i;
            sdo_q  <= lsb_i ? tx_i[0] : tx_i[7];
        end else if (edge_hit) begin
            sck_q  <= ~sck_q;
            cnt_q  <= '0;
            half_q <= half_q + 4'd1;
            busy_q <= half_q != 4'd15;
            if (lead) begin
                samp_q <= sdi_i;
                sdo_q  <= out_bit;
            end else begin
                sh_q <= sh_d;
            end
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/spi_host.sv
// spi_host: Z80 I/O-mapped SPI master with chip selects, modes, divider and first-byte guard
module spi_host
    import spi_host_pkg::*;
#(
    parameter logic [15:0]        BASE_ADDR = 16'h0100,
    parameter int                 NUM_CS    = 2,
    parameter int                 DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = '0,
    parameter int                 WAIT_TAIL = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              phi_edge_i,
    input  logic              io_read_i,
    input  logic              io_write_i,
    input  logic [15:0]       addr_i,
    input  logic [7:0]        din_i,
    output logic [7:0]        dout_o,
    output logic              dout_en_o,
    output logic              wait_en_o,
    output logic              spi_sck_o,
    output logic              spi_sdo_o,
    input  logic              spi_sdi_i,
    output logic [NUM_CS-1:0] spi_ss_o
);
    state_e               state_q;
    logic [6:0]           ctrl_q;
    logic                 fault_q, armed_q, dout_en_q, wait_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [7:0]           dout_q, rx, tx_d;
    logic [3:0]           half, rem;
    logic                 rd, wr, a_ctrl, a_div, a_data, idle, trip, start, busy;

    assign rd     = io_read_i;
    assign wr     = io_write_i & ~io_read_i;
    assign a_ctrl = addr_i == BASE_ADDR + OFF_CTRL;
    assign a_div  = addr_i == BASE_ADDR + OFF_DIV;
    assign a_data = addr_i == BASE_ADDR + OFF_DATA;
    assign idle   = state_q == ST_IDLE;
    assign trip   = idle & wr & a_data & armed_q & is_guard(din_i);
    assign start  = idle & (rd | wr) & a_data & ~trip;
    assign tx_d   = rd ? 8'hFF : din_i;
    assign rem    = 4'd8 - {1'b0, half[3:1]};
    assign dout_o    = dout_q;
    assign dout_en_o = dout_en_q;
    assign wait_en_o = wait_q;

    spi_host_shifter #(.DIV_WIDTH(DIV_WIDTH)) u_shifter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start),
        .tx_i    (tx_d),
        .div_i   (div_q),
        .cpol_i  (ctrl_q[CPOL]),
        .cpha_i  (ctrl_q[CPHA]),
        .lsb_i   (ctrl_q[LSB]),
        .sdi_i   (spi_sdi_i),
        .sck_o   (spi_sck_o),
        .sdo_o   (spi_sdo_o),
        .busy_o  (busy),
        .rx_o    (rx),
        .half_o  (half)
    );

    // one active-low select follows cs_en; out-of-range cs_sel leaves every line high
    always_comb begin
        for (int i = 0; i < NUM_CS; i++) spi_ss_o[i] = ~(ctrl_q[CS_EN] && ctrl_q[2:0] == 3'(i));
    end

    // bus FSM; register writes and the guard only act from IDLE so each bus cycle does one thing
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            fault_q <= 1'b0;
            armed_q <= 1'b0;
            div_q   <= DIV_RESET;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((rd | wr) & (a_ctrl | a_div)) begin
                        state_q <= ST_COMPLETE;
                        if (wr & a_ctrl) begin
                            ctrl_q  <= din_i[6:0];
                            fault_q <= fault_q & ~din_i[7];
                            armed_q <= din_i[CS_EN] & (armed_q | ~ctrl_q[CS_EN]);
                        end
                        if (wr & a_div) div_q <= DIV_WIDTH'(din_i);
                    end else if (trip) begin
                        state_q       <= ST_COMPLETE;
                        ctrl_q[CS_EN] <= 1'b0;
                        fault_q       <= 1'b1;
                        armed_q       <= 1'b0;
                    end else if (start) begin
                        state_q <= ST_XFER;
                        armed_q <= armed_q & ~wr;
                    end
                end
                ST_XFER:  if (!busy) state_q <= (io_read_i | io_write_i) ? ST_COMPLETE : ST_IDLE;
                default:  if (!io_read_i && !io_write_i) state_q <= ST_IDLE;
            endcase
        end
    end

    // read data, bus drive enable and /WAIT, all registered toward the Z80
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q    <= 8'h00;
            dout_en_q <= 1'b0;
            wait_q    <= 1'b0;
        end else begin
            dout_en_q <= rd & (a_ctrl | a_div | a_data);
            dout_q    <= (state_q == ST_XFER && !busy) ? rx :
                         (rd & a_ctrl) ? {fault_q, ctrl_q} :
                         (rd & a_div) ? 8'(div_q) : dout_q;
            wait_q    <= state_q != ST_XFER ? 1'b0 :
                         phi_edge_i ? (rd & a_data & (rem > 4'(WAIT_TAIL))) : wait_q;
        end
    end
endmodule
